// File: rtl/regfile_pkg.sv
// Shared defaults and read-port packing helpers for the multi-port register file.
// Macro REGFILE_BYPASS_EN (consumed by regfile_mp/regfile_sb) selects write-to-read forwarding.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 3;
    localparam int MAX_NUM_RD = 8;

    // Low bit of read port 'port' within a packed bus of 'width'-bit slices.
    function automatic int rd_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_sb.sv
// Busy scoreboard: reserve sets, write clears, reserve wins on the same address.
// Latency: updates at the next edge; with REGFILE_BYPASS_EN the view shows the post-edge vector.
// Backpressure: none, busy is advisory and never stalls writes.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DEPTH-1:0]  busy_view
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Reserve applied last so a new producer overrides a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (!reset) begin
            if (we0)    busy_d[waddr0]   = 1'b0;
            if (we1)    busy_d[waddr1]   = 1'b0;
            if (rsv_en) busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

`ifdef REGFILE_BYPASS_EN
    assign busy_view = busy_d;
`else
    assign busy_view = busy_q;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Register file, 2 write ports, NUM_RD combinational read ports, debug port, busy scoreboard.
// Latency: writes land at the next edge; macro REGFILE_BYPASS_EN forwards them to the read ports.
// Backpressure: none; port 1 wins a same-address write collision.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] mem_d  [DEPTH];
    logic [DATA_W-1:0] rd_src [DEPTH];
    logic [DEPTH-1:0]  busy_view;

    always_comb begin
        mem_d = mem_q;
        if (!reset) begin
            if (we0 && (waddr0 != '0 || ZERO_REG == 0)) mem_d[waddr0] = wdata0;
            if (we1 && (waddr1 != '0 || ZERO_REG == 0)) mem_d[waddr1] = wdata1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

    // mem_d equals mem_q while reset is high, so forwarded reads are zero then too.
`ifdef REGFILE_BYPASS_EN
    always_comb rd_src = mem_d;
`else
    always_comb rd_src = mem_q;
`endif

    regfile_sb #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clock     (clock),
        .reset     (reset),
        .we0       (we0),
        .waddr0    (waddr0),
        .we1       (we1),
        .waddr1    (waddr1),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .busy_view (busy_view)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = raddr[rd_lo(k, ADDR_W) +: ADDR_W];
        assign rdata[rd_lo(k, DATA_W) +: DATA_W] = rd_src[addr];
        assign rbusy[k] = busy_view[addr];
    end

    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 3, number of read ports (1..8).
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = entry 0 hardwired to zero.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port we0  input  1  write enable, port 0.
REQ-008 SHALL have port waddr0  input  ADDR_W  write address, port 0.
REQ-009 SHALL have port wdata0  input  DATA_W  write data, port 0.
REQ-010 SHALL have port we1  input  1  write enable, port 1.
REQ-011 SHALL have port waddr1  input  ADDR_W  write address, port 1.
REQ-012 SHALL have port wdata1  input  DATA_W  write data, port 1.
REQ-013 SHALL have port raddr  input  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
REQ-014 SHALL have port rdata  output  NUM_RD*DATA_W  packed read data; same packing as raddr.
REQ-015 SHALL have port rbusy  output  NUM_RD  scoreboard busy flag of each read address.
REQ-016 SHALL have port rsv_en  input  1  reserve request; marks one register pending.
REQ-017 SHALL have port rsv_addr  input  ADDR_W  register to reserve.
REQ-018 SHALL have port dbg_addr  input  ADDR_W  debug read address.
REQ-019 SHALL have port dbg_data  output  DATA_W  debug read data.

Function
REQ-020 Reads SHALL be combinational; rdata[k] = entry[raddr[k]]; rbusy[k] = busy[raddr[k]].
REQ-021 With ZERO_REG=1, address 0 SHALL read 0, SHALL ignore writes, SHALL never be busy, and reserves to it SHALL be dropped.
REQ-022 weN=1 SHALL store wdataN to entry[waddrN] at the next rising edge; latency one cycle.
REQ-023 Both ports writing the same address in one cycle: port 1 data SHALL win.
REQ-024 A write SHALL clear busy[waddr] at the same edge.
REQ-025 rsv_en=1 SHALL set busy[rsv_addr] at the next edge.
REQ-026 Reserve and write to the same address in one cycle: busy SHALL end set (reserve wins; new producer).
REQ-027 Writes to non-busy registers SHALL be accepted; busy is advisory, not a write gate.
REQ-028 dbg_data SHALL show stored contents only, never bypassed data; address 0 per REQ-021.

Reset
REQ-029 reset high SHALL immediately, independent of clock, clear all entries to 0 and all busy bits to 0.
REQ-030 While reset is high, writes and reserves SHALL be ignored; rdata, rbusy, dbg_data SHALL read 0.
REQ-031 First edge after reset deassertion SHALL accept writes and reserves normally.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN defined: a read of an address written this cycle SHALL return the winning write data and rbusy SHALL reflect the post-edge value (write-to-read forwarding, reserve priority per REQ-026).
REQ-033 Macro REGFILE_BYPASS_EN undefined: reads SHALL return pre-edge stored data and busy; no forwarding logic present.

Structure
REQ-034 Package regfile_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD constants and the read-port slice helper widths.
REQ-035 Scoreboard SHALL be a sub-module regfile_sb (busy vector, reserve/clear, priority, reset).

Verification
REQ-036 Reset mid-run: write 0xDEADBEEF to r5, assert reset between edges -> r5 and dbg_data read 0 immediately.
REQ-037 Dual write collision: we0/we1 both to r7, wdata0=0x11, wdata1=0x22 -> r7 reads 0x22 next cycle.
REQ-038 Zero register: write 0xFFFFFFFF to r0 and reserve r0 -> rdata=0, rbusy=0.
REQ-039 Scoreboard: reserve r3, then write r3=0x55 two cycles later -> rbusy 1 for two cycles, then 0 with data 0x55; same-cycle reserve+write r3 -> busy stays 1.
REQ-040 Bypass: write r9=0xA5A5 while all read ports read r9 -> with REGFILE_BYPASS_EN 0xA5A5 same cycle; without, old value until next cycle; dbg_data old value in both.
